// File: rtl/router_pkt_tx_pkg.sv
// Shared router definitions: packet header field layout and the TX sequencer states.
package router_pkt_tx_pkg;
    localparam int DW       = 8;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 2;
    localparam int LEN_LSB  = 2;
    localparam int LEN_W    = 6;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HEADER,
        TX_PAYLOAD,
        TX_PARITY,
        TX_DRAIN
    } tx_state_e;

    function automatic logic [DW-1:0] mk_header(input logic [LEN_W-1:0] len,
                                                input logic [ADDR_W-1:0] addr);
        logic [DW-1:0] hdr;
        hdr = '0;
        hdr[LEN_LSB +: LEN_W]   = len;
        hdr[ADDR_LSB +: ADDR_W] = addr;
        return hdr;
    endfunction
endpackage

// File: rtl/router_pkt_tx_if.sv
// Host-side load/start controls plus the router input-port handshake.
interface router_pkt_tx_if;
    import router_pkt_tx_pkg::*;

    logic              wr_en;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic [ADDR_W-1:0] dest_addr;
    logic              busy;
    logic              pkt_valid;
    logic [DW-1:0]     data_out;
    logic              tx_active;
    logic              tx_done;
    logic              err;
    logic [LEN_W-1:0]  buf_count;

    modport master (
        input  wr_en, wr_data, start, dest_addr, busy,
        output pkt_valid, data_out, tx_active, tx_done, err, buf_count
    );

    modport slave (
        output wr_en, wr_data, start, dest_addr, busy,
        input  pkt_valid, data_out, tx_active, tx_done, err, buf_count
    );
endinterface

// File: rtl/router_tx_buf.sv
// Payload byte buffer: append-only writes, whole-buffer clear, combinational read.
module router_tx_buf
    import router_pkt_tx_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          clr,
    input  logic [AW-1:0] rd_ptr,
    output logic [AW-1:0] count,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [DEPTH];

    // Contents need no reset; count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) mem[count] <= wr_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)    count <= '0;
        else if (clr)   count <= '0;
        else if (wr_en) count <= count + AW'(1);
    end

    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: header, buffered payload, then parity,
// stalling on router busy and waiting out the router's parity check before done.
module router_pkt_tx
    import router_pkt_tx_pkg::*;
#(
    parameter int MAX_LEN = 63
) (
    input logic             clock,
    input logic             resetn,
    router_pkt_tx_if.master bus
);
    tx_state_e        state;
    logic [LEN_W-1:0] len_q, rd_ptr, rd_addr, buf_cnt, cnt_eff;
    logic [DW-1:0]    data_q, par_q, rd_data;
    logic             pvld_q, act_q, done_q, err_q;
    logic [1:0]       seen;   // [0] busy observed high, [1] grace cycle elapsed
    logic             wr_ok, drain_done;

    assign wr_ok   = bus.wr_en && (state == TX_IDLE) && (buf_cnt < LEN_W'(MAX_LEN));
    // A write in the same cycle as start counts toward the packet length.
    assign cnt_eff = buf_cnt + LEN_W'(wr_ok);
    // Output register is loaded one byte ahead, so read the next index.
    assign rd_addr = (state == TX_HEADER) ? '0 : rd_ptr + LEN_W'(1);
    assign drain_done = (state == TX_DRAIN) && !bus.busy && (seen != 2'b00);

    router_tx_buf #(.DEPTH(64), .AW(LEN_W)) u_buf (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_ok),
        .wr_data (bus.wr_data),
        .clr     (drain_done),
        .rd_ptr  (rd_addr),
        .count   (buf_cnt),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= TX_IDLE;
            len_q  <= '0;
            rd_ptr <= '0;
            data_q <= '0;
            par_q  <= '0;
            pvld_q <= 1'b0;
            act_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            seen   <= 2'b00;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                TX_IDLE: if (bus.start) begin
                    if (cnt_eff == '0 || bus.dest_addr == ADDR_INVALID) begin
                        err_q <= 1'b1;
                    end else begin
                        state  <= TX_HEADER;
                        len_q  <= cnt_eff;
                        rd_ptr <= '0;
                        pvld_q <= 1'b1;
                        act_q  <= 1'b1;
                        data_q <= mk_header(cnt_eff, bus.dest_addr);
                    end
                end
                TX_HEADER: if (!bus.busy) begin
                    par_q  <= data_q;
                    data_q <= rd_data;
                    rd_ptr <= '0;
                    state  <= TX_PAYLOAD;
                end
                TX_PAYLOAD: if (!bus.busy) begin
                    par_q <= par_q ^ data_q;
                    if (rd_ptr == len_q - LEN_W'(1)) begin
                        state  <= TX_PARITY;
                        pvld_q <= 1'b0;
                        data_q <= par_q ^ data_q;
                    end else begin
                        rd_ptr <= rd_ptr + LEN_W'(1);
                        data_q <= rd_data;
                    end
                end
                TX_PARITY: if (!bus.busy) begin
                    state  <= TX_DRAIN;
                    data_q <= '0;
                    seen   <= 2'b00;
                end
                TX_DRAIN: begin
                    if (drain_done) begin
                        state  <= TX_IDLE;
                        done_q <= 1'b1;
                        act_q  <= 1'b0;
                    end else begin
                        seen[1] <= 1'b1;
                        if (bus.busy) seen[0] <= 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    assign bus.pkt_valid = pvld_q;
    assign bus.data_out  = data_q;
    assign bus.tx_active = act_q;
    assign bus.tx_done   = done_q;
    assign bus.err       = err_q;
    assign bus.buf_count = buf_cnt;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: byte stream, stalls, rejects, full buffer, reset.
module tb_router_pkt_tx;
    logic clock;
    logic resetn;
    int   n_cmp;
    int   n_err;
    logic [7:0] exp_pl [64];
    logic [7:0] par;

    router_pkt_tx_if bus();

    router_pkt_tx #(.MAX_LEN(63)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = exp_pl[i];
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] addr);
        bus.start     = 1'b1;
        bus.dest_addr = addr;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic start_err(input string tag, input logic [1:0] addr, input int cnt);
        do_start(addr);
        chk({tag, "_err"}, bus.err, 1);
        chk({tag, "_pvld"}, bus.pkt_valid, 0);
        chk({tag, "_act"}, bus.tx_active, 0);
        chk({tag, "_cnt"}, bus.buf_count, cnt);
        tick();
        chk({tag, "_err_clr"}, bus.err, 0);
    endtask

    // Entered just after the start edge; header is on the outputs.
    task automatic expect_pkt(input string tag, input logic [7:0] hdr, input int len,
                              input logic [7:0] p, input int stall_idx, input int stall_n,
                              input int inj_idx);
        logic [7:0] e;
        logic       ev;
        int         cyc;
        for (int k = 0; k <= len + 1; k++) begin
            e  = (k == 0) ? hdr : (k <= len) ? exp_pl[k-1] : p;
            ev = (k <= len);
            chk({tag, "_data"}, bus.data_out, e);
            chk({tag, "_pvld"}, bus.pkt_valid, ev);
            if (k == 0) chk({tag, "_act"}, bus.tx_active, 1);
            if (k == stall_idx) begin
                bus.busy = 1'b1;
                repeat (stall_n) begin
                    tick();
                    chk({tag, "_hold_data"}, bus.data_out, e);
                    chk({tag, "_hold_pvld"}, bus.pkt_valid, ev);
                end
                bus.busy = 1'b0;
            end
            if (k == inj_idx) begin
                bus.wr_en     = 1'b1;
                bus.wr_data   = 8'hEE;
                bus.start     = 1'b1;
                bus.dest_addr = 2'd0;
            end
            tick();
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
            if (k == inj_idx) chk({tag, "_inj_cnt"}, bus.buf_count, len);
        end
        chk({tag, "_drain_pvld"}, bus.pkt_valid, 0);
        chk({tag, "_drain_data"}, bus.data_out, 0);
        cyc = 0;
        while (!bus.tx_done && cyc < 8) begin
            tick();
            cyc++;
        end
        chk({tag, "_done_lat"}, cyc, 2);
        chk({tag, "_done_cnt"}, bus.buf_count, 0);
        chk({tag, "_done_act"}, bus.tx_active, 0);
        tick();
        chk({tag, "_done_pulse"}, bus.tx_done, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn        = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.start     = 1'b0;
        bus.dest_addr = 2'd0;
        bus.busy      = 1'b0;
        repeat (2) tick();
        chk("rst_pvld", bus.pkt_valid, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_cnt", bus.buf_count, 0);
        chk("rst_act", bus.tx_active, 0);
        chk("rst_done", bus.tx_done, 0);
        chk("rst_err", bus.err, 0);
        resetn = 1'b1;
        tick();

        // 3-byte packet to port 1, no stalls
        exp_pl[0] = 8'h11; exp_pl[1] = 8'h22; exp_pl[2] = 8'h33;
        load(3);
        chk("t1_cnt", bus.buf_count, 3);
        do_start(2'd1);
        expect_pkt("t1", 8'h0D, 3, 8'h0D, -1, 0, -1);

        // Same packet, second payload byte held by busy for 4 cycles
        load(3);
        do_start(2'd1);
        expect_pkt("t2", 8'h0D, 3, 8'h0D, 2, 4, -1);

        // Rejected starts keep the buffer
        start_err("e_empty", 2'd0, 0);
        exp_pl[0] = 8'h44; exp_pl[1] = 8'h55;
        load(2);
        start_err("e_addr3", 2'd3, 2);
        do_start(2'd2);
        expect_pkt("t3", 8'h0A, 2, 8'h1B, -1, 0, -1);

        // Full buffer, 64th write dropped
        par = 8'hFE;
        for (int i = 0; i < 63; i++) begin
            exp_pl[i] = 8'(i * 5 + 3);
            par = par ^ exp_pl[i];
        end
        load(63);
        bus.wr_en = 1'b1; bus.wr_data = 8'hAA;
        tick();
        bus.wr_en = 1'b0;
        chk("full_cnt", bus.buf_count, 63);
        do_start(2'd2);
        expect_pkt("t63", 8'hFE, 63, par, -1, 0, -1);

        // Async reset mid-payload
        exp_pl[0] = 8'h01; exp_pl[1] = 8'h02; exp_pl[2] = 8'h04; exp_pl[3] = 8'h08;
        load(4);
        do_start(2'd0);
        chk("r_hdr", bus.data_out, 8'h10);
        tick();
        tick();
        chk("r_mid_data", bus.data_out, 8'h02);
        #2 resetn = 1'b0;
        #1;
        chk("r_pvld", bus.pkt_valid, 0);
        chk("r_cnt", bus.buf_count, 0);
        chk("r_act", bus.tx_active, 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("r_idle_pvld", bus.pkt_valid, 0);

        // Write and start in the same cycle: length includes the new byte
        exp_pl[0] = 8'h5A; exp_pl[1] = 8'hA5;
        load(1);
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        bus.start = 1'b1; bus.dest_addr = 2'd0;
        tick();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        expect_pkt("t_ws", 8'h08, 2, 8'hF7, -1, 0, -1);

        // wr_en and start during payload are ignored
        exp_pl[0] = 8'h11; exp_pl[1] = 8'h22; exp_pl[2] = 8'h33;
        load(3);
        do_start(2'd1);
        expect_pkt("t_inj", 8'h0D, 3, 8'h0D, -1, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source that drives the 1x3 router input port (pkt_valid, data_in, busy) under the router's receive protocol.
- Software or a testbench loads up to 63 payload bytes into an internal buffer, then issues start with a destination address.
- The block emits the header byte, the payload bytes and the parity byte, holding data whenever the router asserts busy.
- Sits between the host/stimulus side and the router top; it is also the synthesizable traffic generator used in router system benches.

Parameters:
- MAX_LEN, 63, maximum payload bytes; the header length field is 6 bits, so 1..63.
- DW, 8, byte width; fixed at 8 by the packet format.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  payload buffer write strobe.
- wr_data  in  8  payload byte to append.
- start  in  1  single-cycle request to send the buffered packet.
- dest_addr  in  2  destination port, 0..2.
- busy  in  1  router busy; when high the current byte is not accepted.
- pkt_valid  out  1  high for the header and payload bytes; low for the parity byte.
- data_out  out  8  byte to the router data_in.
- tx_active  out  1  high from the cycle after an accepted start until tx_done.
- tx_done  out  1  one-cycle pulse when the packet has completed.
- err  out  1  one-cycle pulse when start is rejected.
- buf_count  out  6  number of bytes currently buffered.

Behaviour:
- Reset (async, resetn=0): state IDLE, buf_count=0, pkt_valid=0, data_out=0, tx_active=0, tx_done=0, err=0, parity accumulator=0.
- Buffer writes:
  - wr_en in IDLE with buf_count<MAX_LEN: store wr_data at index buf_count, then buf_count+1.
  - wr_en when buf_count==MAX_LEN, or in any non-IDLE state: ignored, no error.
- Start:
  - start in IDLE with buf_count==0 or dest_addr==3: err=1 next cycle, stay IDLE, buffer kept.
  - start with wr_en in the same cycle: the write is performed first and the start uses the updated count.
  - start outside IDLE: ignored.
- FSM: IDLE -> HEADER -> PAYLOAD -> PARITY -> DRAIN -> IDLE.
- HEADER (entered the cycle after an accepted start):
  - pkt_valid=1, data_out={len[5:0],dest_addr}; len and addr are latched at start.
  - The parity accumulator loads the header byte on acceptance.
- Acceptance rule:
  - A byte is accepted on a rising edge where busy=0.
  - While busy=1, data_out and pkt_valid hold stable and no pointer advances.
  - In HEADER, acceptance moves to PAYLOAD with rd_ptr=0.
- PAYLOAD:
  - pkt_valid=1, data_out=buf[rd_ptr].
  - On acceptance: parity ^= byte and rd_ptr+1.
  - The last byte (rd_ptr==len-1) accepted -> PARITY.
  - pkt_valid never drops between header and last payload byte; the full payload is buffered first, so bubbles are impossible.
- PARITY:
  - pkt_valid=0, data_out=parity, the XOR of the header and all payload bytes.
  - Held until an edge with busy=0 -> DRAIN.
- DRAIN:
  - pkt_valid=0, data_out=0.
  - Wait for busy to go high and then low again (the router passes through its parity/check states); a two-bit seen-busy flag tracks this.
  - If busy is still low 2 cycles after entering DRAIN, complete anyway.
  - On completion: tx_done=1 for one cycle, buf_count=0, return to IDLE, tx_active=0.
- Latency: minimum with busy=0 throughout is len+2 cycles of data, start to pkt_valid fall = len+1 cycles after the HEADER entry.
- Reset mid-packet: immediate IDLE, pkt_valid=0 asynchronously, buffer contents discarded (count=0).
- Outputs are registered; no combinational path from busy to data_out or pkt_valid.

Decomposition:
- Shared router package holds:
  - state encodings for TX_IDLE/HEADER/PAYLOAD/PARITY/DRAIN;
  - the header field constants: ADDR_LSB=0, ADDR_W=2, LEN_LSB=2, LEN_W=6;
  - ADDR_INVALID=2'b11.
- One sub-module: router_tx_buf, a 64x8 register array with write pointer/count and combinational read at rd_ptr. The FSM, parity and handshake stay in router_pkt_tx.

Test Plan:
- Write 3 bytes 0x11,0x22,0x33, start dest=1, busy=0:
  - header 0x0D (len 3, addr 1) with pkt_valid=1;
  - then 0x11,0x22,0x33 on consecutive cycles;
  - then parity 0x0D^0x11^0x22^0x33=0x0D with pkt_valid=0;
  - tx_done pulses, buf_count=0.
- Same packet with busy held high for 4 cycles during the second payload byte: 0x22 stays on data_out for all 5 cycles, pkt_valid stays 1, and the byte sequence is unchanged.
- start with buf_count=0, and separately start with dest_addr=3: err pulses one cycle, pkt_valid stays 0, and the buffer retains any data.
- Load 63 bytes, then attempt a 64th write:
  - buf_count stays 63;
  - header equals 0xFC|addr;
  - 63 payload bytes are emitted, then the correct parity.
- Assert resetn=0 mid-PAYLOAD: pkt_valid=0 without waiting for a clock edge; after release state=IDLE, buf_count=0, and a new packet sends correctly.
- wr_en and start during PAYLOAD: both are ignored, and buf_count/output sequence are unaffected.
